// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: SPI slave with configurable word width, CPOL/CPHA mode and
// bit order. All SPI pins are oversampled in the clk_i domain. A single-word
// ready/valid holding register feeds the transmit shifter; underrun and
// frame-abort conditions are reported as one-cycle status pulses.
//
// Transmit handshake: a word on tx_data_i is accepted in a cycle where both
// tx_vld_i and tx_rdy_o are high; tx_rdy_o is high whenever the holding
// register is empty. There is no receive backpressure: rx_vld_o is a single
// cycle pulse and rx_data_o holds the word until the next one completes.
module spi_slave_cfg #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_mosi_i,
    input  logic                  spi_cs_n_i,
    output logic                  spi_miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_vld_i,
    output logic                  tx_rdy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_vld_o,
    output logic                  tx_udr_o,
    output logic                  frm_err_o
);

    localparam int              CNT_W     = $clog2(DATA_WIDTH);
    localparam logic            SCLK_IDLE = (CPOL != 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchroniser chains and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    // Receive path
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic                  rx_vld_q,   rx_vld_d;

    // Transmit path
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q,     hold_d;
    logic                  full_q,     full_d;
    logic                  first_q,    first_d;     // CPHA=1: next shift edge presents, not shifts
    logic                  load_pend_q, load_pend_d; // CPHA=0: next shift edge loads a new word
    logic                  tx_udr_q,   tx_udr_d;
    logic                  frm_err_q,  frm_err_d;
    logic                  miso_q,     miso_d;

    // Synchronised pin views and decoded events
    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic cs_fall, cs_rise, last_sample;
    logic do_load, do_shift;
    logic [DATA_WIDTH-1:0] rx_next, tx_shifted;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign lead_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
    assign trail_edge = (CPOL != 0) ? sclk_rise : sclk_fall;

    // SCLK edges only count while chip select is active; a CS rise in the
    // same cycle as an edge therefore wins automatically.
    assign sample_edge = ~cs_s & ((CPHA != 0) ? trail_edge : lead_edge);
    assign shift_edge  = ~cs_s & ((CPHA != 0) ? lead_edge : trail_edge);

    assign cs_fall     = ~cs_s & cs_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign last_sample = sample_edge & (bit_cnt_q == LAST_BIT);

    assign do_load  = cs_fall |
                      ((CPHA != 0) ? last_sample : (shift_edge & load_pend_q));
    assign do_shift = shift_edge & ~do_load & ((CPHA != 0) ? ~first_q : 1'b1);

    // Shifted versions of the receive and transmit registers for the chosen bit order
    always_comb begin
        rx_next    = rx_shift_q;
        tx_shifted = tx_shift_q;
        if (MSB_FIRST != 0) begin
            rx_next    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            tx_shifted = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rx_next    = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
            tx_shifted = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
        end
    end

    // Next-state logic for synchronisers, receive, transmit and status pulses
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;

        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_vld_d    = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        full_d      = full_q;
        first_d     = first_q;
        load_pend_d = load_pend_q;
        tx_udr_d    = 1'b0;
        frm_err_d   = 1'b0;

        // Receive: idle while deselected, otherwise shift in on sample edges
        if (cs_s) begin
            bit_cnt_d   = '0;
            load_pend_d = 1'b0;
            if (cs_rise && (bit_cnt_q != '0)) begin
                frm_err_d = 1'b1;
            end
        end else if (sample_edge) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                rx_data_d = rx_next;
                rx_vld_d  = 1'b1;
                if (CPHA == 0) begin
                    load_pend_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        // Transmit: load from the holding register at word boundaries, else shift
        if (do_load) begin
            first_d     = 1'b1;
            load_pend_d = 1'b0;
            if (full_q) begin
                tx_shift_d = hold_q;
                full_d     = 1'b0;
            end else begin
                tx_shift_d = '0;
                tx_udr_d   = 1'b1;
            end
        end else if (shift_edge) begin
            first_d = 1'b0;
            if (do_shift) begin
                tx_shift_d = tx_shifted;
            end
        end

        // Holding register accept; a same-cycle load above saw the old state
        if (tx_vld_i && !full_q) begin
            hold_d = tx_data_i;
            full_d = 1'b1;
        end

        // MISO follows next-cycle CS and shifter state so it stays registered
        if (MSB_FIRST != 0) begin
            miso_d = ~cs_sync_q[SYNC_STAGES-2] & tx_shift_d[DATA_WIDTH-1];
        end else begin
            miso_d = ~cs_sync_q[SYNC_STAGES-2] & tx_shift_d[0];
        end
    end

    // State registers; synchronisers reset to idle pin levels so that
    // leaving reset never fabricates an SCLK or CS edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= SCLK_IDLE;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            first_q     <= 1'b0;
            load_pend_q <= 1'b0;
            tx_udr_q    <= 1'b0;
            frm_err_q   <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            first_q     <= first_d;
            load_pend_q <= load_pend_d;
            tx_udr_q    <= tx_udr_d;
            frm_err_q   <= frm_err_d;
            miso_q      <= miso_d;
        end
    end

    assign spi_miso_o = miso_q;
    assign tx_rdy_o   = ~full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_vld_o   = rx_vld_q;
    assign tx_udr_o   = tx_udr_q;
    assign frm_err_o  = frm_err_q;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: five instances cover mode 0..3 at 8 bits and a
// 12-bit LSB-first mode-0 slave. A bit-banged SPI master drives each one.
module tb_spi_slave_cfg;

    localparam int HALF = 8;   // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sclk;
    logic [4:0]  cs_n;
    logic        mosi;
    logic [11:0] tx_data;
    logic [4:0]  tx_vld;

    wire         miso0, miso1, miso2, miso3, miso4;
    wire         rdy0, rdy1, rdy2, rdy3, rdy4;
    wire         vld0, vld1, vld2, vld3, vld4;
    wire         udr0, udr1, udr2, udr3, udr4;
    wire         fe0, fe1, fe2, fe3, fe4;
    wire [7:0]   rxd0, rxd1, rxd2, rxd3;
    wire [11:0]  rxd4;

    wire [4:0]   miso_v   = {miso4, miso3, miso2, miso1, miso0};
    wire [4:0]   tx_rdy_v = {rdy4, rdy3, rdy2, rdy1, rdy0};
    wire [4:0]   rx_vld_v = {vld4, vld3, vld2, vld1, vld0};
    wire [4:0]   udr_v    = {udr4, udr3, udr2, udr1, udr0};
    wire [4:0]   ferr_v   = {fe4, fe3, fe2, fe1, fe0};
    logic [11:0] rx_d [5];

    assign rx_d[0] = {4'h0, rxd0};
    assign rx_d[1] = {4'h0, rxd1};
    assign rx_d[2] = {4'h0, rxd2};
    assign rx_d[3] = {4'h0, rxd3};
    assign rx_d[4] = rxd4;

    int errors = 0;
    int checks = 0;

    // Pulse monitors
    int          rx_cnt [5];
    int          udr_cnt [5];
    int          ferr_cnt [5];
    logic [11:0] rx_hist [5][16];

    // Clock
    always #5 clk = ~clk;

    spi_slave_cfg #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk[0]), .spi_mosi_i(mosi),
        .spi_cs_n_i(cs_n[0]), .spi_miso_o(miso0), .tx_data_i(tx_data[7:0]),
        .tx_vld_i(tx_vld[0]), .tx_rdy_o(rdy0), .rx_data_o(rxd0), .rx_vld_o(vld0),
        .tx_udr_o(udr0), .frm_err_o(fe0));
    spi_slave_cfg #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1)) u1 (
        .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk[1]), .spi_mosi_i(mosi),
        .spi_cs_n_i(cs_n[1]), .spi_miso_o(miso1), .tx_data_i(tx_data[7:0]),
        .tx_vld_i(tx_vld[1]), .tx_rdy_o(rdy1), .rx_data_o(rxd1), .rx_vld_o(vld1),
        .tx_udr_o(udr1), .frm_err_o(fe1));
    spi_slave_cfg #(.DATA_WIDTH(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) u2 (
        .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk[2]), .spi_mosi_i(mosi),
        .spi_cs_n_i(cs_n[2]), .spi_miso_o(miso2), .tx_data_i(tx_data[7:0]),
        .tx_vld_i(tx_vld[2]), .tx_rdy_o(rdy2), .rx_data_o(rxd2), .rx_vld_o(vld2),
        .tx_udr_o(udr2), .frm_err_o(fe2));
    spi_slave_cfg #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u3 (
        .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk[3]), .spi_mosi_i(mosi),
        .spi_cs_n_i(cs_n[3]), .spi_miso_o(miso3), .tx_data_i(tx_data[7:0]),
        .tx_vld_i(tx_vld[3]), .tx_rdy_o(rdy3), .rx_data_o(rxd3), .rx_vld_o(vld3),
        .tx_udr_o(udr3), .frm_err_o(fe3));
    spi_slave_cfg #(.DATA_WIDTH(12), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u4 (
        .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk[4]), .spi_mosi_i(mosi),
        .spi_cs_n_i(cs_n[4]), .spi_miso_o(miso4), .tx_data_i(tx_data),
        .tx_vld_i(tx_vld[4]), .tx_rdy_o(rdy4), .rx_data_o(rxd4), .rx_vld_o(vld4),
        .tx_udr_o(udr4), .frm_err_o(fe4));

    // Count status pulses per instance on the inactive edge
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst) begin
                rx_cnt[k] = rx_cnt[k];
            end
            if (rx_vld_v[k]) begin
                rx_hist[k][rx_cnt[k] % 16] = rx_d[k];
                rx_cnt[k] = rx_cnt[k] + 1;
            end
            if (udr_v[k])  udr_cnt[k]  = udr_cnt[k] + 1;
            if (ferr_v[k]) ferr_cnt[k] = ferr_cnt[k] + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word to the holding register of instance k
    task automatic tx_push(input int k, input logic [11:0] d);
        int n;
        n = 0;
        while (!tx_rdy_v[k] && n < 100) begin
            wait_clk(1);
            n++;
        end
        checks++;
        if (tx_rdy_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL push%0d_timeout: tx_rdy=%b required 1", k, tx_rdy_v[k]);
        end else begin
            tx_data   = d;
            tx_vld[k] = 1'b1;
            wait_clk(1);
            tx_vld[k] = 1'b0;
        end
    endtask

    task automatic cs_low(input int k);
        cs_n[k] = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic cs_high(input int k);
        wait_clk(HALF);
        cs_n[k] = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Bit-banged master: nb bits of mo out, read back into mi, fb = first bit seen
    task automatic xfer(input int k, input logic cpol, input int cpha, input int w,
                        input int msb, input int nb, input logic [11:0] mo,
                        output logic [11:0] mi, output logic fb);
        int b;
        mi = '0;
        fb = 1'b0;
        for (int i = 0; i < nb; i++) begin
            b = (msb != 0) ? (w - 1 - i) : i;
            if (cpha == 0) begin
                mosi = mo[b];
                wait_clk(HALF);
                mi[b] = miso_v[k];
                if (i == 0) fb = miso_v[k];
                sclk[k] = ~cpol;
                wait_clk(HALF);
                sclk[k] = cpol;
            end else begin
                sclk[k] = ~cpol;
                mosi = mo[b];
                wait_clk(HALF);
                mi[b] = miso_v[k];
                if (i == 0) fb = miso_v[k];
                sclk[k] = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(4);
        checks++; if (miso_v !== 5'h00) begin errors++; $display("FAIL reset_miso: got %h required 00", miso_v); end
        checks++; if (tx_rdy_v !== 5'h1f) begin errors++; $display("FAIL reset_tx_rdy: got %h required 1f", tx_rdy_v); end
        checks++; if (rx_vld_v !== 5'h00) begin errors++; $display("FAIL reset_rx_vld: got %h required 00", rx_vld_v); end
        checks++; if (udr_v !== 5'h00) begin errors++; $display("FAIL reset_udr: got %h required 00", udr_v); end
        checks++; if (ferr_v !== 5'h00) begin errors++; $display("FAIL reset_frm_err: got %h required 00", ferr_v); end
        checks++; if (rx_d[0] !== 12'h000) begin errors++; $display("FAIL reset_rx_data0: got %h required 000", rx_d[0]); end
        checks++; if (rx_d[4] !== 12'h000) begin errors++; $display("FAIL reset_rx_data4: got %h required 000", rx_d[4]); end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mode0;
        int rx0;
        logic [11:0] mi;
        logic fb;
        rx0 = rx_cnt[0];
        tx_push(0, 12'h0A5);
        checks++; if (tx_rdy_v[0] !== 1'b0) begin errors++; $display("FAIL m0_rdy_full: got %b required 0", tx_rdy_v[0]); end
        cs_low(0);
        checks++; if (tx_rdy_v[0] !== 1'b1) begin errors++; $display("FAIL m0_rdy_after_load: got %b required 1", tx_rdy_v[0]); end
        xfer(0, 1'b0, 0, 8, 1, 8, 12'h03C, mi, fb);
        cs_high(0);
        checks++; if (mi !== 12'h0A5) begin errors++; $display("FAIL m0_miso: got %h required 0a5", mi); end
        checks++; if (rx_d[0] !== 12'h03C) begin errors++; $display("FAIL m0_rx_data: got %h required 03c", rx_d[0]); end
        checks++; if (rx_cnt[0] - rx0 !== 1) begin errors++; $display("FAIL m0_rx_pulses: got %0d required 1", rx_cnt[0] - rx0); end
    endtask

    // Two back-to-back words in one frame; a third word is queued during
    // word 2 so the load at the end of the frame also finds data
    task automatic test_modes(input int k, input logic cpol, input int cpha);
        int rx0, ud0, fe0;
        logic [11:0] m1, m2;
        logic fb;
        rx0 = rx_cnt[k]; ud0 = udr_cnt[k]; fe0 = ferr_cnt[k];
        tx_push(k, 12'h055);
        cs_low(k);
        tx_push(k, 12'h0AA);
        xfer(k, cpol, cpha, 8, 1, 8, 12'h081, m1, fb);
        tx_push(k, 12'h000);
        xfer(k, cpol, cpha, 8, 1, 8, 12'h07E, m2, fb);
        cs_high(k);
        checks++; if (rx_cnt[k] - rx0 !== 2) begin errors++; $display("FAIL mode%0d_rx_pulses: got %0d required 2", k, rx_cnt[k] - rx0); end
        checks++; if (rx_hist[k][rx0 % 16] !== 12'h081) begin errors++; $display("FAIL mode%0d_rx_w1: got %h required 081", k, rx_hist[k][rx0 % 16]); end
        checks++; if (rx_hist[k][(rx0 + 1) % 16] !== 12'h07E) begin errors++; $display("FAIL mode%0d_rx_w2: got %h required 07e", k, rx_hist[k][(rx0 + 1) % 16]); end
        checks++; if (m1 !== 12'h055) begin errors++; $display("FAIL mode%0d_miso_w1: got %h required 055", k, m1); end
        checks++; if (m2 !== 12'h0AA) begin errors++; $display("FAIL mode%0d_miso_w2: got %h required 0aa", k, m2); end
        checks++; if (udr_cnt[k] - ud0 !== 0) begin errors++; $display("FAIL mode%0d_udr: got %0d required 0", k, udr_cnt[k] - ud0); end
        checks++; if (ferr_cnt[k] - fe0 !== 0) begin errors++; $display("FAIL mode%0d_frm_err: got %0d required 0", k, ferr_cnt[k] - fe0); end
    endtask

    task automatic test_wide_lsb;
        int rx0;
        logic [11:0] mi;
        logic fb;
        rx0 = rx_cnt[4];
        tx_push(4, 12'h123);
        cs_low(4);
        xfer(4, 1'b0, 0, 12, 0, 12, 12'hABC, mi, fb);
        cs_high(4);
        checks++; if (rx_d[4] !== 12'hABC) begin errors++; $display("FAIL w12_rx_data: got %h required abc", rx_d[4]); end
        checks++; if (rx_cnt[4] - rx0 !== 1) begin errors++; $display("FAIL w12_rx_pulses: got %0d required 1", rx_cnt[4] - rx0); end
        checks++; if (mi !== 12'h123) begin errors++; $display("FAIL w12_miso: got %h required 123", mi); end
        checks++; if (fb !== 1'b1) begin errors++; $display("FAIL w12_first_bit: got %b required 1", fb); end
    endtask

    // Mode 0 with an empty holding register: every load (CS fall and each
    // word end, including the last) finds nothing and pulses underrun
    task automatic test_underrun;
        int ud0;
        logic [11:0] m1, m2;
        logic fb;
        ud0 = udr_cnt[0];
        cs_low(0);
        checks++; if (udr_cnt[0] - ud0 !== 1) begin errors++; $display("FAIL udr_cs_fall: got %0d required 1", udr_cnt[0] - ud0); end
        xfer(0, 1'b0, 0, 8, 1, 8, 12'h012, m1, fb);
        wait_clk(HALF / 2);
        checks++; if (udr_cnt[0] - ud0 !== 2) begin errors++; $display("FAIL udr_word1: got %0d required 2", udr_cnt[0] - ud0); end
        xfer(0, 1'b0, 0, 8, 1, 8, 12'h034, m2, fb);
        cs_high(0);
        checks++; if (udr_cnt[0] - ud0 !== 3) begin errors++; $display("FAIL udr_word2: got %0d required 3", udr_cnt[0] - ud0); end
        checks++; if (m1 !== 12'h000) begin errors++; $display("FAIL udr_miso_w1: got %h required 000", m1); end
        checks++; if (m2 !== 12'h000) begin errors++; $display("FAIL udr_miso_w2: got %h required 000", m2); end
    endtask

    task automatic test_abort;
        int rx0, fe0;
        logic [11:0] mi;
        logic fb;
        rx0 = rx_cnt[0]; fe0 = ferr_cnt[0];
        cs_low(0);
        xfer(0, 1'b0, 0, 8, 1, 5, 12'h069, mi, fb);
        cs_high(0);
        checks++; if (ferr_cnt[0] - fe0 !== 1) begin errors++; $display("FAIL abort_frm_err: got %0d required 1", ferr_cnt[0] - fe0); end
        checks++; if (rx_cnt[0] - rx0 !== 0) begin errors++; $display("FAIL abort_rx_pulses: got %0d required 0", rx_cnt[0] - rx0); end
        checks++; if (rx_d[0] !== 12'h034) begin errors++; $display("FAIL abort_rx_held: got %h required 034", rx_d[0]); end
        cs_low(0);
        xfer(0, 1'b0, 0, 8, 1, 8, 12'h096, mi, fb);
        cs_high(0);
        checks++; if (rx_d[0] !== 12'h096) begin errors++; $display("FAIL abort_next_rx: got %h required 096", rx_d[0]); end
        checks++; if (rx_cnt[0] - rx0 !== 1) begin errors++; $display("FAIL abort_next_pulses: got %0d required 1", rx_cnt[0] - rx0); end
        checks++; if (ferr_cnt[0] - fe0 !== 1) begin errors++; $display("FAIL abort_next_frm_err: got %0d required 1", ferr_cnt[0] - fe0); end
    endtask

    task automatic test_reset_mid;
        int rx0, fe0;
        logic [11:0] mi;
        logic fb;
        rx0 = rx_cnt[0]; fe0 = ferr_cnt[0];
        cs_low(0);
        tx_push(0, 12'h077);
        xfer(0, 1'b0, 0, 8, 1, 4, 12'h0F0, mi, fb);
        wait_clk(HALF);
        rst = 1'b1;
        wait_clk(2);
        cs_n[0] = 1'b1;
        wait_clk(3);
        checks++; if (miso_v[0] !== 1'b0) begin errors++; $display("FAIL rmid_miso: got %b required 0", miso_v[0]); end
        checks++; if (tx_rdy_v[0] !== 1'b1) begin errors++; $display("FAIL rmid_tx_rdy: got %b required 1", tx_rdy_v[0]); end
        checks++; if (rx_d[0] !== 12'h000) begin errors++; $display("FAIL rmid_rx_data: got %h required 000", rx_d[0]); end
        checks++; if (rx_vld_v[0] !== 1'b0) begin errors++; $display("FAIL rmid_rx_vld: got %b required 0", rx_vld_v[0]); end
        checks++; if (udr_v[0] !== 1'b0) begin errors++; $display("FAIL rmid_udr: got %b required 0", udr_v[0]); end
        checks++; if (ferr_v[0] !== 1'b0) begin errors++; $display("FAIL rmid_frm_err: got %b required 0", ferr_v[0]); end
        rst = 1'b0;
        wait_clk(8);
        cs_low(0);
        xfer(0, 1'b0, 0, 8, 1, 8, 12'h05A, mi, fb);
        cs_high(0);
        checks++; if (rx_d[0] !== 12'h05A) begin errors++; $display("FAIL rmid_rx_after: got %h required 05a", rx_d[0]); end
        checks++; if (rx_cnt[0] - rx0 !== 1) begin errors++; $display("FAIL rmid_rx_pulses: got %0d required 1", rx_cnt[0] - rx0); end
        checks++; if (ferr_cnt[0] - fe0 !== 0) begin errors++; $display("FAIL rmid_frm_err_cnt: got %0d required 0", ferr_cnt[0] - fe0); end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rx_cnt[k] = 0; udr_cnt[k] = 0; ferr_cnt[k] = 0;
        end
        rst     = 1'b1;
        sclk    = 5'b01100;
        cs_n    = 5'b11111;
        mosi    = 1'b0;
        tx_data = '0;
        tx_vld  = '0;

        test_reset();
        test_mode0();
        test_modes(1, 1'b0, 1);
        test_modes(2, 1'b1, 0);
        test_modes(3, 1'b1, 1);
        test_wide_lsb();
        test_underrun();
        test_abort();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_cfg.md
Name: spi_slave_cfg

Overview:
Parametrised SPI slave that generalises the fixed mode-0, 8-bit byte slave. All SPI pins are oversampled in the clk_i domain. It adds:
- configurable word width, CPOL/CPHA mode and bit order;
- a ready/valid transmit holding register;
- underrun and frame-abort status pulses.
It sits between an external SPI master pin interface and the internal byte/word stream logic (LED frame parser, register file).

Parameters:
DATA_WIDTH, 8, bits per SPI word (≥4).
CPOL, 0, idle level of SCLK.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
SYNC_STAGES, 2, synchroniser flops on sclk/mosi/cs_n (≥2).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
spi_sclk_i  in  1  SPI clock, asynchronous
spi_mosi_i  in  1  SPI data in, asynchronous
spi_cs_n_i  in  1  chip select, active-low, asynchronous
spi_miso_o  out  1  SPI data out
tx_data_i  in  DATA_WIDTH  next word to transmit
tx_vld_i  in  1  tx_data_i valid
tx_rdy_o  out  1  holding register empty
rx_data_o  out  DATA_WIDTH  last received word
rx_vld_o  out  1  one-cycle pulse: rx_data_o updated
tx_udr_o  out  1  one-cycle pulse: word loaded with holding register empty
frm_err_o  out  1  one-cycle pulse: CS deasserted mid-word

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: all registers cleared. spi_miso_o=0, rx_data_o=0, rx_vld_o=0, tx_udr_o=0, frm_err_o=0, tx_rdy_o=1 (holding register empty).
- Reset mid-frame: the partial word is discarded and no pulses are generated.
- Synchronisation and edge detection:
  - sclk, mosi and cs_n each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised sclk against a one-cycle-delayed copy.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge.
- Timing constraint: SCLK high and low times must each be ≥3 clk_i cycles.
- CS handling:
  - Edges are ignored while synchronised cs_n=1; bit_cnt is held at 0.
  - spi_miso_o is driven 0 while cs_n=1 (no tristate).
  - Synchronised cs_n falling edge → load the shifter (see Load).
- Receive:
  - On each sample edge the synchronised mosi enters rx_shift. It enters at bit 0 with a left shift if MSB_FIRST=1, else at bit DATA_WIDTH-1 with a right shift.
  - bit_cnt increments on each sample edge.
  - On the sample edge with bit_cnt==DATA_WIDTH-1: bit_cnt wraps to 0 and the completed word is registered into rx_data_o.
  - rx_vld_o pulses high for exactly 1 cycle, in the cycle after that sample-edge detect cycle.
  - There is no receive backpressure: the consumer must take each word within DATA_WIDTH sample edges.
- Transmit output: spi_miso_o = tx_shift[DATA_WIDTH-1] if MSB_FIRST=1, else tx_shift[0].
- Transmit shifting:
  - CPHA=0: shift on every shift edge, except the shift edge following a word's last sample, which does Load instead.
  - CPHA=1: the first shift edge of each word does not shift (the loaded bit is already presented); every later shift edge shifts. The last sample edge of a word performs Load.
  - Vacated bits fill with 0.
- Load:
  - If the holding register is full, copy it to tx_shift and clear full.
  - Otherwise load all-zero and pulse tx_udr_o for 1 cycle.
- Holding register:
  - Accepts on tx_vld_i & tx_rdy_o; tx_rdy_o = ~full.
  - Accept and Load in the same cycle: Load uses the pre-cycle state (empty → underrun, zeros). The accepted word then sets full.
  - A word accepted while cs_n=1 is loaded at the next cs_n fall.
- Frame abort:
  - Synchronised cs_n rising with bit_cnt≠0 → frm_err_o pulse for 1 cycle. The partial word is discarded; rx_vld_o and rx_data_o are unchanged.
  - cs_n rising with bit_cnt==0 → no pulse.
  - Holding register content is preserved across frames.
- Simultaneous events: a cs_n rising edge in the same cycle as a sample edge takes priority; the edge is ignored.

Test Plan:
- Mode 0, W=8, MSB first. Preload tx 0xA5; master sends 0x3C. Required: rx_data_o=0x3C with a single rx_vld_o pulse; master reads 0xA5; tx_rdy_o=1 after the CS-fall load.
- Modes 1, 2 and 3 each with W=8. Master sends 0x81, 0x7E back-to-back in one CS frame; tx preloaded 0x55, then 0xAA accepted during word 1. Required: rx words 0x81, 0x7E; MISO words 0x55, 0xAA; no tx_udr_o.
- W=12, MSB_FIRST=0. Master sends 0xABC; tx preloaded 0x123. Required: rx_data_o=0xABC; master reads 0x123 with the LSB transmitted first.
- Underrun: no tx preload, 2-word frame. Required: tx_udr_o pulses at CS fall and at the word boundary; MISO reads 0x00, 0x00.
- Abort: CS raised after 5 bits. Required: frm_err_o pulses once; no rx_vld_o; the next full frame of 0x96 is received correctly as 0x96.
- Reset asserted mid-word and then released, followed by a full frame of 0x5A. Required: all outputs at reset values during reset; 0x5A received correctly with a single rx_vld_o pulse.
